// File: rtl/wb_bus_if_if.sv
// Wishbone B3 classic bus bundle between the CPU bus bridge and a slave.
// The master drives the request side; the slave returns data and ack.
interface wb_bus_if_if;
    logic [31:0] wb_addr_o;
    logic [31:0] wb_data_o;
    logic        wb_we_o;
    logic [3:0]  wb_sel_o;
    logic        wb_stb_o;
    logic        wb_cyc_o;
    logic [31:0] wb_data_i;
    logic        wb_ack_i;

    modport master (
        output wb_addr_o, wb_data_o, wb_we_o,
        output wb_sel_o, wb_stb_o, wb_cyc_o,
        input  wb_data_i, wb_ack_i
    );

    modport slave (
        input  wb_addr_o, wb_data_o, wb_we_o,
        input  wb_sel_o, wb_stb_o, wb_cyc_o,
        output wb_data_i, wb_ack_i
    );
endinterface

// File: rtl/wb_bus_if.sv
// CPU-side Wishbone master: one classic transfer at a time, pipeline
// stall handshake, flush abort, read data held while downstream stalls.
module wb_bus_if #(
    parameter int STALL_W = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [STALL_W-1:0] stall_i,
    input  logic               flush_i,
    input  logic               cpu_ce_i,
    input  logic [31:0]        cpu_addr_i,
    input  logic [31:0]        cpu_data_i,
    input  logic               cpu_we_i,
    input  logic [3:0]         cpu_sel_i,
    output logic [31:0]        cpu_data_o,
    output logic               stallreq_o,
    wb_bus_if_if.master        wb
);

    localparam logic [1:0] IDLE       = 2'd0;
    localparam logic [1:0] BUSY       = 2'd1;
    localparam logic [1:0] WAIT_STALL = 2'd2;

    logic [1:0]  state;
    logic [31:0] rd_buf;
    logic [31:0] addr_q;
    logic [31:0] data_q;
    logic        we_q;
    logic [3:0]  sel_q;
    logic        cyc_q;

    assign wb.wb_addr_o = addr_q;
    assign wb.wb_data_o = data_q;
    assign wb.wb_we_o   = we_q;
    assign wb.wb_sel_o  = sel_q;
    assign wb.wb_stb_o  = cyc_q;
    assign wb.wb_cyc_o  = cyc_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            rd_buf <= '0;
            addr_q <= '0;
            data_q <= '0;
            we_q   <= 1'b0;
            sel_q  <= '0;
            cyc_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (cpu_ce_i && !flush_i) begin
                        state  <= BUSY;
                        addr_q <= cpu_addr_i;
                        data_q <= cpu_data_i;
                        we_q   <= cpu_we_i;
                        sel_q  <= cpu_sel_i;
                        cyc_q  <= 1'b1;
                    end
                end
                BUSY: begin
                    // flush outranks ack: acked data is dropped
                    if (flush_i || wb.wb_ack_i) begin
                        addr_q <= '0;
                        data_q <= '0;
                        we_q   <= 1'b0;
                        sel_q  <= '0;
                        cyc_q  <= 1'b0;
                    end
                    if (flush_i) begin
                        state  <= IDLE;
                        rd_buf <= '0;
                    end else if (wb.wb_ack_i) begin
                        rd_buf <= wb.wb_data_i;
                        state  <= (|stall_i) ? WAIT_STALL : IDLE;
                    end
                end
                WAIT_STALL: begin
                    if (flush_i) begin
                        state  <= IDLE;
                        rd_buf <= '0;
                    end else if (!(|stall_i)) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        stallreq_o = 1'b0;
        cpu_data_o = '0;
        if (!rst) begin
            case (state)
                IDLE:       stallreq_o = cpu_ce_i;
                BUSY:       stallreq_o = !wb.wb_ack_i;
                default:    stallreq_o = 1'b0;
            endcase
            if (flush_i)
                stallreq_o = 1'b0;
            if (state == BUSY && wb.wb_ack_i)
                cpu_data_o = wb.wb_data_i;
            else if (state == WAIT_STALL)
                cpu_data_o = rd_buf;
        end
    end

endmodule

// File: tb/tb_wb_bus_if.sv
// Directed vector table for the bus bridge corner cases, then random
// traffic compared against a transaction-level reference model.
module tb_wb_bus_if;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  stall;
    logic        flush;
    logic        ce;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] cpu_data;
    logic        stallreq;

    wb_bus_if_if bus();

    wb_bus_if #(.STALL_W(6)) dut (
        .clk        (clk),
        .rst        (rst),
        .stall_i    (stall),
        .flush_i    (flush),
        .cpu_ce_i   (ce),
        .cpu_addr_i (addr),
        .cpu_data_i (wdata),
        .cpu_we_i   (we),
        .cpu_sel_i  (sel),
        .cpu_data_o (cpu_data),
        .stallreq_o (stallreq),
        .wb         (bus.master)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [5:0]  stall;
        logic        flush;
        logic        ce;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        we;
        logic [3:0]  sel;
        logic        ack;
        logic [31:0] rdata;
        logic        e_sr;
        logic [31:0] e_data;
        logic        e_cyc;
        logic [31:0] e_addr;
        logic [31:0] e_wdata;
        logic        e_we;
        logic [3:0]  e_sel;
    } vec_t;

    vec_t vq[$];
    int   n_pass = 0;
    int   n_total = 0;

    task automatic chk(input string nm, input int row,
                       input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s row %0d: got %h expected %h", nm, row, act, exp);
    endtask

    task automatic v(input logic r, input logic [5:0] st, input logic fl,
                     input logic c, input logic [31:0] a, input logic [31:0] wd,
                     input logic w, input logic [3:0] s, input logic ak,
                     input logic [31:0] rd, input logic esr, input logic [31:0] ed,
                     input logic ecyc, input logic [31:0] ea, input logic [31:0] ewd,
                     input logic ewe, input logic [3:0] es);
        vec_t x;
        x.rst = r; x.stall = st; x.flush = fl; x.ce = c;
        x.addr = a; x.wdata = wd; x.we = w; x.sel = s;
        x.ack = ak; x.rdata = rd;
        x.e_sr = esr; x.e_data = ed; x.e_cyc = ecyc; x.e_addr = ea;
        x.e_wdata = ewd; x.e_we = ewe; x.e_sel = es;
        vq.push_back(x);
    endtask

    task automatic drive(input logic r, input logic [5:0] st, input logic fl,
                         input logic c, input logic [31:0] a, input logic [31:0] wd,
                         input logic w, input logic [3:0] s, input logic ak,
                         input logic [31:0] rd);
        rst = r; stall = st; flush = fl; ce = c;
        addr = a; wdata = wd; we = w; sel = s;
        bus.wb_ack_i = ak; bus.wb_data_i = rd;
    endtask

    task automatic compare(input int row, input logic esr, input logic [31:0] ed,
                           input logic ecyc, input logic [31:0] ea,
                           input logic [31:0] ewd, input logic ewe,
                           input logic [3:0] es);
        chk("stallreq", row, {31'd0, stallreq}, {31'd0, esr});
        chk("cpu_data", row, cpu_data, ed);
        chk("cyc", row, {31'd0, bus.wb_cyc_o}, {31'd0, ecyc});
        chk("stb", row, {31'd0, bus.wb_stb_o}, {31'd0, ecyc});
        chk("addr", row, bus.wb_addr_o, ea);
        chk("wdata", row, bus.wb_data_o, ewd);
        chk("we", row, {31'd0, bus.wb_we_o}, {31'd0, ewe});
        chk("sel", row, {28'd0, bus.wb_sel_o}, {28'd0, es});
    endtask

    // transaction-level reference: an outstanding request, or held read data
    logic        m_open;
    logic        m_held;
    logic [31:0] m_buf;
    logic [31:0] m_addr, m_wd;
    logic        m_we;
    logic [3:0]  m_sel;

    localparam logic [5:0] S5 = 6'b011111;
    localparam logic [5:0] S1 = 6'b000010;

    initial begin
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        // reset, request ignored while rst
        v(1,0,0,1,32'h100,0,0,4'hF,0,0, 0,0,0,0,0,0,0);
        v(1,0,0,0,0,0,0,0,0,0,          0,0,0,0,0,0,0);
        // zero-wait read
        v(0,0,0,1,32'h100,0,0,4'hF,0,0, 1,0,0,0,0,0,0);
        v(0,0,0,1,32'h100,0,0,4'hF,1,32'hDEADBEEF,
          0,32'hDEADBEEF,1,32'h100,0,0,4'hF);
        v(0,0,0,0,0,0,0,0,0,0,          0,0,0,0,0,0,0);
        // write, 3 wait states, ce dropped while busy
        v(0,0,0,1,32'h200,32'h12345678,1,4'h3,0,0, 1,0,0,0,0,0,0);
        v(0,0,0,1,32'h200,32'h12345678,1,4'h3,0,0,
          1,0,1,32'h200,32'h12345678,1,4'h3);
        v(0,0,0,0,0,0,0,0,0,0, 1,0,1,32'h200,32'h12345678,1,4'h3);
        v(0,0,0,0,0,0,0,0,0,0, 1,0,1,32'h200,32'h12345678,1,4'h3);
        v(0,0,0,0,0,0,0,0,1,32'h77,
          0,32'h77,1,32'h200,32'h12345678,1,4'h3);
        v(0,0,0,0,0,0,0,0,0,0,          0,0,0,0,0,0,0);
        // read completing into a stalled pipeline
        v(0,0,0,1,32'h300,0,0,4'hF,0,0, 1,0,0,0,0,0,0);
        v(0,S5,0,1,32'h300,0,0,4'hF,1,32'hCAFE0001,
          0,32'hCAFE0001,1,32'h300,0,0,4'hF);
        v(0,S5,0,1,32'h300,0,0,4'hF,0,0, 0,32'hCAFE0001,0,0,0,0,0);
        v(0,S5,0,1,32'h300,0,0,4'hF,0,0, 0,32'hCAFE0001,0,0,0,0,0);
        v(0,S5,0,1,32'h300,0,0,4'hF,0,0, 0,32'hCAFE0001,0,0,0,0,0);
        v(0,0,0,0,0,0,0,0,0,0,          0,32'hCAFE0001,0,0,0,0,0);
        v(0,0,0,0,0,0,0,0,0,0,          0,0,0,0,0,0,0);
        // flush in 2nd busy cycle, then back-to-back reads
        v(0,0,0,1,32'h400,0,0,4'hF,0,0, 1,0,0,0,0,0,0);
        v(0,0,0,1,32'h400,0,0,4'hF,0,0, 1,0,1,32'h400,0,0,4'hF);
        v(0,0,1,1,32'h400,0,0,4'hF,0,0, 0,0,1,32'h400,0,0,4'hF);
        v(0,0,0,1,32'h404,0,0,4'hF,0,0, 1,0,0,0,0,0,0);
        v(0,0,0,1,32'h404,0,0,4'hF,1,32'h11112222,
          0,32'h11112222,1,32'h404,0,0,4'hF);
        v(0,0,0,1,32'h408,0,0,4'h1,0,0, 1,0,0,0,0,0,0);
        v(0,0,0,1,32'h408,0,0,4'h1,1,32'h33334444,
          0,32'h33334444,1,32'h408,0,0,4'h1);
        v(0,0,0,0,0,0,0,0,0,0,          0,0,0,0,0,0,0);
        // flush together with ack: nothing held despite stall
        v(0,0,0,1,32'h500,0,0,4'hF,0,0, 1,0,0,0,0,0,0);
        v(0,S5,1,1,32'h500,0,0,4'hF,1,32'h5555AAAA,
          0,32'h5555AAAA,1,32'h500,0,0,4'hF);
        v(0,S5,0,0,0,0,0,0,0,0,         0,0,0,0,0,0,0);
        v(0,0,0,0,0,0,0,0,0,0,          0,0,0,0,0,0,0);
        // flush while holding data
        v(0,0,0,1,32'h700,0,0,4'hF,0,0, 1,0,0,0,0,0,0);
        v(0,S1,0,1,32'h700,0,0,4'hF,1,32'hABCD0123,
          0,32'hABCD0123,1,32'h700,0,0,4'hF);
        v(0,S1,0,0,0,0,0,0,0,0,         0,32'hABCD0123,0,0,0,0,0);
        v(0,S1,1,0,0,0,0,0,0,0,         0,32'hABCD0123,0,0,0,0,0);
        v(0,S1,0,0,0,0,0,0,0,0,         0,0,0,0,0,0,0);
        // flush blocks a start from idle
        v(0,0,1,1,32'h800,0,0,4'hF,0,0, 0,0,0,0,0,0,0);
        v(0,0,0,0,0,0,0,0,0,0,          0,0,0,0,0,0,0);
        // reset mid-transfer, late ack ignored
        v(0,0,0,1,32'h600,32'hA5,1,4'hC,0,0, 1,0,0,0,0,0,0);
        v(0,0,0,1,32'h600,32'hA5,1,4'hC,0,0, 1,0,1,32'h600,32'hA5,1,4'hC);
        v(1,0,0,1,32'h600,32'hA5,1,4'hC,0,0, 0,0,1,32'h600,32'hA5,1,4'hC);
        v(0,0,0,0,0,0,0,0,1,32'h99,     0,0,0,0,0,0,0);
        v(0,0,0,0,0,0,0,0,0,0,          0,0,0,0,0,0,0);

        @(posedge clk); #1;
        foreach (vq[i]) begin
            drive(vq[i].rst, vq[i].stall, vq[i].flush, vq[i].ce,
                  vq[i].addr, vq[i].wdata, vq[i].we, vq[i].sel,
                  vq[i].ack, vq[i].rdata);
            @(negedge clk);
            compare(i, vq[i].e_sr, vq[i].e_data, vq[i].e_cyc,
                    vq[i].e_addr, vq[i].e_wdata, vq[i].e_we, vq[i].e_sel);
            @(posedge clk); #1;
        end

        // random phase, starting from reset so model and DUT agree
        m_open = 0; m_held = 0; m_buf = 0;
        m_addr = 0; m_wd = 0; m_we = 0; m_sel = 0;
        for (int k = 0; k < 400; k++) begin
            logic        r, fl, c, w, ak;
            logic [5:0]  st;
            logic [3:0]  s;
            logic [31:0] a, wd, rd;
            logic        esr;
            logic [31:0] ed;
            r  = (k == 0) || ($urandom_range(0, 40) == 0);
            fl = ($urandom_range(0, 7) == 0);
            c  = ($urandom_range(0, 2) != 0);
            ak = ($urandom_range(0, 2) == 0);
            st = ($urandom_range(0, 2) == 0) ? 6'($urandom) : 6'd0;
            a  = $urandom; wd = $urandom; rd = $urandom;
            w  = 1'($urandom); s = 4'($urandom);
            drive(r, st, fl, c, a, wd, w, s, ak, rd);

            esr = 0; ed = 0;
            if (!r) begin
                if (m_open) esr = !ak;
                else if (!m_held) esr = c;
                if (fl) esr = 0;
                if (m_open && ak) ed = rd;
                else if (m_held) ed = m_buf;
            end
            @(negedge clk);
            if (m_open)
                compare(1000 + k, esr, ed, 1, m_addr, m_wd, m_we, m_sel);
            else
                compare(1000 + k, esr, ed, 0, 0, 0, 0, 0);

            if (r) begin
                m_open = 0; m_held = 0; m_buf = 0;
            end else if (m_open) begin
                if (fl) begin
                    m_open = 0; m_buf = 0;
                end else if (ak) begin
                    m_open = 0; m_buf = rd; m_held = (st != 0);
                end
            end else if (m_held) begin
                if (fl) begin
                    m_held = 0; m_buf = 0;
                end else if (st == 0) begin
                    m_held = 0;
                end
            end else if (c && !fl) begin
                m_open = 1; m_addr = a; m_wd = wd; m_we = w; m_sel = s;
            end
            @(posedge clk); #1;
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/wb_bus_if.md
WB_BUS_IF -- requirements
Module: wb_bus_if

Interface
REQ-001 SHALL have parameter STALL_W, default 6, pipeline stall vector width (bit0 = PC stage).
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port stall_i  input  STALL_W  stall vector from pipeline controller.
REQ-005 SHALL have port flush_i  input  1  exception flush from pipeline controller.
REQ-006 SHALL have port cpu_ce_i  input  1  CPU access request (held until served).
REQ-007 SHALL have port cpu_addr_i  input  32  access address.
REQ-008 SHALL have port cpu_data_i  input  32  write data.
REQ-009 SHALL have port cpu_we_i  input  1  1 = write, 0 = read.
REQ-010 SHALL have port cpu_sel_i  input  4  byte lane select.
REQ-011 SHALL have port cpu_data_o  output  32  read data to CPU.
REQ-012 SHALL have port stallreq_o  output  1  stall request to pipeline controller (IF or MEM slot).
REQ-013 SHALL have ports wb_data_i  input  32 and wb_ack_i  input  1  Wishbone slave read data and acknowledge.
REQ-014 SHALL have ports wb_addr_o 32, wb_data_o 32, wb_we_o 1, wb_sel_o 4, wb_stb_o 1, wb_cyc_o 1, all outputs, Wishbone B3 classic master signals, all registered.

Function
REQ-015 SHALL implement FSM states IDLE, BUSY, WAIT_STALL; one Wishbone transfer at a time, no bursts.
REQ-016 IDLE: if cpu_ce_i=1 and flush_i=0, SHALL on next edge register cyc=stb=1, addr/data/we/sel from CPU inputs, go BUSY; otherwise remain IDLE with all wb_* outputs 0.
REQ-017 BUSY, wb_ack_i=1, flush_i=0: SHALL on next edge clear cyc, stb, we, sel, addr, data to 0, capture wb_data_i into read buffer rd_buf, go WAIT_STALL if stall_i != 0, else IDLE.
REQ-018 BUSY, wb_ack_i=0: SHALL hold all wb_* outputs unchanged.
REQ-019 BUSY, flush_i=1 (regardless of ack): SHALL on next edge clear all wb_* outputs, clear rd_buf, go IDLE; acked data discarded.
REQ-020 WAIT_STALL: SHALL go IDLE on the edge where stall_i = 0 or flush_i = 1; flush also clears rd_buf.
REQ-021 stallreq_o SHALL be combinational: IDLE -> cpu_ce_i & ~flush_i; BUSY -> ~wb_ack_i; WAIT_STALL -> 0; forced 0 while flush_i=1 in any state.
REQ-022 cpu_data_o SHALL be combinational: BUSY with wb_ack_i=1 -> wb_data_i; WAIT_STALL -> rd_buf; otherwise 0.
REQ-023 Minimum latency: request seen in IDLE at cycle n, stb high cycle n+1, zero-wait ack at n+1 -> stallreq_o low and data valid at n+1, state IDLE at n+2.
REQ-024 A request arriving in the IDLE cycle immediately after a completed transfer SHALL start a new transfer (back-to-back, one idle cycle between stb pulses).
REQ-025 cpu_ce_i deassertion while BUSY SHALL NOT abort the transfer; only flush_i aborts.
REQ-026 Write transfers SHALL follow the same FSM; rd_buf captures wb_data_i regardless (don't-care content).

Reset
REQ-027 With rst=1 at a clock edge, SHALL force state IDLE, all wb_* outputs 0, rd_buf 0, regardless of state or pending ack (reset mid-transfer abandons the cycle).
REQ-028 During rst=1, stallreq_o and cpu_data_o SHALL be 0.
REQ-029 rst SHALL have priority over flush_i, which has priority over wb_ack_i.

Verification
REQ-030 Read, zero wait: cpu_ce=1, addr=0x0000_0100, we=0, sel=0xF; slave acks first stb cycle with 0xDEAD_BEEF -> stb/cyc 1 cycle, stallreq high 1 cycle, cpu_data_o=0xDEADBEEF in ack cycle, IDLE next.
REQ-031 Write, 3 wait states: addr=0x0000_0200, data=0x1234_5678, we=1, sel=0x3 -> wb outputs stable 4 cycles, stallreq high through 3 waits, low in ack cycle, all wb_* 0 after.
REQ-032 Stalled downstream: read acks 0xCAFE_0001 while stall_i=6'b011111 held 3 more cycles -> WAIT_STALL, cpu_data_o=0xCAFE0001 every held cycle, stallreq 0, IDLE when stall_i=0.
REQ-033 Flush mid-transfer: flush_i=1 in 2nd BUSY cycle, no ack -> stallreq 0 that cycle, cyc/stb 0 next edge, IDLE, rd_buf 0; new request afterwards proceeds normally.
REQ-034 Simultaneous flush and ack: flush_i=1 and wb_ack_i=1 same cycle with data 0x5555_AAAA -> data not captured, rd_buf 0, IDLE.
REQ-035 Reset mid-transfer: rst=1 while BUSY and ack pending -> next edge all outputs 0, IDLE; ack arriving after reset ignored.
